j_vtim: RTL and testbench

- Video horizontal/vertical timing generator, directly downstream of the clock divider block.
- Consumes its divided video clock (vclkdiv) and video enable (vclken) in the sys_clk domain.
- Produces pixel/line counters, sync, blank and a vertical-interrupt strobe for the pixel pipeline.
- Programmed through the same 16-bit register write bus (din + strobe) used by the clock register writes.

---
 rtl/j_vtim.sv | 135 +++++++++++++
 tb/tb_j_vtim.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/j_vtim.sv
// Video horizontal/vertical timing generator: pixel/line counters, syncs, blank
// and a vertical interrupt, clocked by rising edges of the divided video clock.
module j_vtim #(
   parameter int HW = 11,
   parameter int VW = 11
) (
   input  logic          sys_clk,
   input  logic          resetl,
   input  logic          vclkdiv,
   input  logic          vclken,
   input  logic [15:0]   din,
   input  logic [3:0]    addr,
   input  logic          wr,
   output logic [15:0]   dout,
   output logic [HW-1:0] hc,
   output logic [VW-1:0] vc,
   output logic          hsyncl,
   output logic          vsyncl,
   output logic          blank,
   output logic          vint
);

   logic [HW-1:0] hp_r, hs_r, hbb_r, hbe_r;
   logic [VW-1:0] vp_r, vs_r, vbb_r, vbe_r, vi_r;
   logic [HW-1:0] hc_r, hc_next_s;
   logic [VW-1:0] vc_r, vc_next_s;
   logic          vclk_d_r, tick_s, eol_s;
   logic          hsyncl_r, vsyncl_r, blank_r, vint_r;
   logic          hblank_s, vblank_s;
   logic          unused_s;

   // Register bits above the counter width are never stored.
   assign unused_s = ^din[15:HW];

   assign tick_s = vclkdiv & ~vclk_d_r & vclken;

   // Timing register file writes.
   always_ff @(posedge sys_clk) begin
      if (!resetl) begin
         hp_r  <= HW'(16'h03FF);
         hs_r  <= HW'(16'h0040);
         hbb_r <= HW'(16'h0300);
         hbe_r <= HW'(16'h0080);
         vp_r  <= VW'(16'h020C);
         vs_r  <= VW'(16'h0006);
         vbb_r <= VW'(16'h01F0);
         vbe_r <= VW'(16'h0020);
         vi_r  <= VW'(16'h07FF);
      end else if (wr) begin
         case (addr)
            4'd0:    hp_r  <= din[HW-1:0];
            4'd1:    hs_r  <= din[HW-1:0];
            4'd2:    hbb_r <= din[HW-1:0];
            4'd3:    hbe_r <= din[HW-1:0];
            4'd4:    vp_r  <= din[VW-1:0];
            4'd5:    vs_r  <= din[VW-1:0];
            4'd6:    vbb_r <= din[VW-1:0];
            4'd7:    vbe_r <= din[VW-1:0];
            4'd8:    vi_r  <= din[VW-1:0];
            default: begin end
         endcase
      end
   end

   // Next counter values assuming a tick; >= keeps a shrunken period from running away.
   always_comb begin
      eol_s     = (hc_r >= hp_r);
      hc_next_s = hc_r;
      vc_next_s = vc_r;
      if (eol_s) begin
         hc_next_s = {HW{1'b0}};
         if (vc_r >= vp_r) begin
            vc_next_s = {VW{1'b0}};
         end else begin
            vc_next_s = vc_r + VW'(1);
         end
      end else begin
         hc_next_s = hc_r + HW'(1);
         vc_next_s = vc_r;
      end
      hblank_s = (hc_next_s >= hbb_r) | (hc_next_s < hbe_r);
      vblank_s = (vc_next_s >= vbb_r) | (vc_next_s < vbe_r);
   end

   // Counters and timing outputs advance together so they stay coherent.
   always_ff @(posedge sys_clk) begin
      if (!resetl) begin
         vclk_d_r <= 1'b1;
         hc_r     <= {HW{1'b0}};
         vc_r     <= {VW{1'b0}};
         hsyncl_r <= 1'b1;
         vsyncl_r <= 1'b1;
         blank_r  <= 1'b1;
         vint_r   <= 1'b0;
      end else begin
         vclk_d_r <= vclkdiv;
         vint_r   <= 1'b0;
         if (tick_s) begin
            hc_r     <= hc_next_s;
            vc_r     <= vc_next_s;
            hsyncl_r <= ~(hc_next_s < hs_r);
            vsyncl_r <= ~(vc_next_s < vs_r);
            blank_r  <= hblank_s | vblank_s;
            vint_r   <= eol_s & (vc_next_s == vi_r);
         end
      end
   end

   // Register and live counter readback.
   always_comb begin
      dout = 16'h0000;
      case (addr)
         4'd0:    dout = 16'(hp_r);
         4'd1:    dout = 16'(hs_r);
         4'd2:    dout = 16'(hbb_r);
         4'd3:    dout = 16'(hbe_r);
         4'd4:    dout = 16'(vp_r);
         4'd5:    dout = 16'(vs_r);
         4'd6:    dout = 16'(vbb_r);
         4'd7:    dout = 16'(vbe_r);
         4'd8:    dout = 16'(vi_r);
         4'd10:   dout = 16'(hc_r);
         4'd11:   dout = 16'(vc_r);
         default: dout = 16'h0000;
      endcase
   end

   assign hc     = hc_r;
   assign vc     = vc_r;
   assign hsyncl = hsyncl_r;
   assign vsyncl = vsyncl_r;
   assign blank  = blank_r;
   assign vint   = vint_r;

endmodule

// File: tb/tb_j_vtim.sv
// Directed bench for j_vtim: register table vectors, default-timing run,
// small-frame walk, period shrink, enable hold and mid-frame reset.
module tb_j_vtim;

   logic        sys_clk = 1'b0;
   logic        resetl, vclkdiv, vclken, wr;
   logic [15:0] din, dout;
   logic [3:0]  addr;
   logic [10:0] hc, vc;
   logic        hsyncl, vsyncl, blank, vint;

   int checks = 0;
   int failures = 0;
   int vint_cnt = 0;
   int base;
   logic ph_vint;
   int hc_e, vc_e;

   typedef struct packed {
      logic        wr;
      logic [3:0]  addr;
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;
   vec_t vec [0:35];

   j_vtim dut (
      .sys_clk(sys_clk), .resetl(resetl), .vclkdiv(vclkdiv), .vclken(vclken),
      .din(din), .addr(addr), .wr(wr), .dout(dout), .hc(hc), .vc(vc),
      .hsyncl(hsyncl), .vsyncl(vsyncl), .blank(blank), .vint(vint)
   );

   always #5 sys_clk = ~sys_clk;

   // Count interrupt-high cycles; a stretched pulse counts more than once.
   always @(negedge sys_clk) if (vint) vint_cnt <= vint_cnt + 1;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One vclkdiv rise; returns with the post-tick state visible.
   task automatic pix();
      vclkdiv = 1'b0;
      cyc(2);
      vclkdiv = 1'b1;
      cyc(1);
      ph_vint = vint;
      cyc(1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) pix();
   endtask

   task automatic wreg(input logic [3:0] a, input logic [15:0] d);
      addr = a;
      din  = d;
      wr   = 1'b1;
      cyc(1);
      wr   = 1'b0;
   endtask

   task automatic apply(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         addr = vec[i].addr;
         din  = vec[i].din;
         wr   = vec[i].wr;
         cyc(1);
         wr   = 1'b0;
         chk($sformatf("vec%0d_addr%0d", i, vec[i].addr), 32'(dout), 32'(vec[i].exp));
      end
   endtask

   function automatic logic [31:0] st(input logic v);
      return {6'd0, hc, vc, blank, hsyncl, vsyncl, v};
   endfunction

   function automatic logic [31:0] mk(input int h, input int v, input logic b,
                                      input logic hs, input logic vs, input logic vi);
      return {6'd0, 11'(h), 11'(v), b, hs, vs, vi};
   endfunction

   initial begin
      // Default register readback after reset
      vec[0]  = '{1'b0, 4'd0,  16'h0000, 16'h03FF};
      vec[1]  = '{1'b0, 4'd1,  16'h0000, 16'h0040};
      vec[2]  = '{1'b0, 4'd2,  16'h0000, 16'h0300};
      vec[3]  = '{1'b0, 4'd3,  16'h0000, 16'h0080};
      vec[4]  = '{1'b0, 4'd4,  16'h0000, 16'h020C};
      vec[5]  = '{1'b0, 4'd5,  16'h0000, 16'h0006};
      vec[6]  = '{1'b0, 4'd6,  16'h0000, 16'h01F0};
      vec[7]  = '{1'b0, 4'd7,  16'h0000, 16'h0020};
      vec[8]  = '{1'b0, 4'd8,  16'h0000, 16'h07FF};
      vec[9]  = '{1'b0, 4'd9,  16'h0000, 16'h0000};
      vec[10] = '{1'b0, 4'd10, 16'h0000, 16'h0000};
      vec[11] = '{1'b0, 4'd11, 16'h0000, 16'h0000};
      vec[12] = '{1'b0, 4'd12, 16'h0000, 16'h0000};
      vec[13] = '{1'b0, 4'd13, 16'h0000, 16'h0000};
      vec[14] = '{1'b0, 4'd14, 16'h0000, 16'h0000};
      vec[15] = '{1'b0, 4'd15, 16'h0000, 16'h0000};
      // Small-frame programming; upper din bits of HP are dropped
      vec[16] = '{1'b1, 4'd0,  16'hF009, 16'h0009};
      vec[17] = '{1'b1, 4'd1,  16'h0002, 16'h0002};
      vec[18] = '{1'b1, 4'd2,  16'h0008, 16'h0008};
      vec[19] = '{1'b1, 4'd3,  16'h0001, 16'h0001};
      vec[20] = '{1'b1, 4'd4,  16'h0003, 16'h0003};
      vec[21] = '{1'b1, 4'd5,  16'h0001, 16'h0001};
      vec[22] = '{1'b1, 4'd6,  16'h0003, 16'h0003};
      vec[23] = '{1'b1, 4'd7,  16'h0000, 16'h0000};
      vec[24] = '{1'b1, 4'd8,  16'h0002, 16'h0002};
      vec[25] = '{1'b1, 4'd13, 16'hFFFF, 16'h0000};
      vec[26] = '{1'b1, 4'd9,  16'hFFFF, 16'h0000};
      vec[27] = '{1'b0, 4'd0,  16'h0000, 16'h0009};
      vec[28] = '{1'b0, 4'd1,  16'h0000, 16'h0002};
      vec[29] = '{1'b0, 4'd2,  16'h0000, 16'h0008};
      vec[30] = '{1'b0, 4'd3,  16'h0000, 16'h0001};
      vec[31] = '{1'b0, 4'd4,  16'h0000, 16'h0003};
      vec[32] = '{1'b0, 4'd5,  16'h0000, 16'h0001};
      vec[33] = '{1'b0, 4'd6,  16'h0000, 16'h0003};
      vec[34] = '{1'b0, 4'd7,  16'h0000, 16'h0000};
      vec[35] = '{1'b0, 4'd8,  16'h0000, 16'h0002};

      // Reset with a write pending and vclkdiv already high
      resetl = 1'b0; vclkdiv = 1'b1; vclken = 1'b1;
      wr = 1'b1; addr = 4'd0; din = 16'h0005;
      cyc(2);
      resetl = 1'b1; wr = 1'b0;
      chk("reset_state", st(vint), mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0));
      cyc(3);
      chk("no_tick_after_reset", st(vint), mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0));
      apply(0, 15);

      // Default timing
      pix();
      chk("dflt_hc1", st(ph_vint), mk(1, 0, 1'b1, 1'b0, 1'b0, 1'b0));
      run(63);
      chk("dflt_hc40_hsync_off", {hc, 20'd0, hsyncl}, {11'h040, 20'd0, 1'b1});
      addr = 4'd10; #1;
      chk("rd_live_hc", 32'(dout), 32'h0040);
      run(959);
      chk("dflt_hc3ff", {hc, vc}, {11'h3FF, 11'h000});
      pix();
      chk("dflt_wrap", {hc, vc}, {11'h000, 11'h001});
      addr = 4'd11; #1;
      chk("rd_live_vc", 32'(dout), 32'h0001);

      // Small frame
      resetl = 1'b0;
      cyc(1);
      resetl = 1'b1;
      apply(16, 35);
      base = vint_cnt;
      hc_e = 0; vc_e = 0;
      for (int t = 0; t < 80; t++) begin
         logic exp_vi;
         exp_vi = 1'b0;
         if (hc_e == 9) begin
            hc_e = 0;
            vc_e = (vc_e == 3) ? 0 : vc_e + 1;
            exp_vi = (vc_e == 2);
         end else begin
            hc_e = hc_e + 1;
         end
         pix();
         chk($sformatf("frame_t%0d", t), st(ph_vint),
             mk(hc_e, vc_e, (hc_e == 0) || (hc_e >= 8) || (vc_e == 3),
                hc_e >= 2, vc_e >= 1, exp_vi));
      end
      chk("vint_per_frame", 32'(vint_cnt - base), 32'd2);

      // Shrink HP below current hc
      run(7);
      chk("pre_shrink", {hc, vc}, {11'd7, 11'd0});
      wreg(4'd0, 16'h0004);
      pix();
      chk("shrink_wrap", {hc, vc}, {11'd0, 11'd1});
      wreg(4'd0, 16'h0009);
      run(4);
      // Write HP=3 on the very edge that ticks: old HP=9 still applies
      vclkdiv = 1'b0;
      cyc(2);
      vclkdiv = 1'b1; wr = 1'b1; addr = 4'd0; din = 16'h0003;
      cyc(1);
      wr = 1'b0;
      cyc(1);
      chk("coincident_old_hp", {hc, vc}, {11'd5, 11'd1});
      pix();
      chk("coincident_new_hp", st(ph_vint), mk(0, 2, 1'b1, 1'b0, 1'b1, 1'b1));
      wreg(4'd0, 16'h0009);

      // Enable hold mid-line
      run(5);
      chk("pre_hold", st(vint), mk(5, 2, 1'b0, 1'b1, 1'b1, 1'b0));
      vclken = 1'b0;
      base = vint_cnt;
      run(50);
      wreg(4'd1, 16'h0007);
      chk("hold_write_hs", 32'(dout), 32'h0007);
      chk("hold_state", st(vint), mk(5, 2, 1'b0, 1'b1, 1'b1, 1'b0));
      chk("hold_no_vint", 32'(vint_cnt - base), 32'd0);
      vclken = 1'b1;
      pix();
      chk("resume", st(ph_vint), mk(6, 2, 1'b0, 1'b0, 1'b1, 1'b0));

      // Mid-frame reset beats a coincident tick and HP write
      vclkdiv = 1'b0;
      cyc(2);
      vclkdiv = 1'b1; resetl = 1'b0; wr = 1'b1; addr = 4'd0; din = 16'h0004;
      cyc(1);
      resetl = 1'b1; wr = 1'b0;
      chk("midreset_state", st(vint), mk(0, 0, 1'b1, 1'b1, 1'b1, 1'b0));
      chk("midreset_hp", 32'(dout), 32'h03FF);
      cyc(3);
      chk("midreset_no_tick", {hc, vc}, {11'd0, 11'd0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
